// File: rtl/i2c_cmd_master.sv
// Write-only I2C master: START, addr+W, cmd, optional arg, STOP.
// Quarter-period sequencer with slave clock-stretch support.
module i2c_cmd_master #(
    parameter int CLK_DIV = 120
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic [7:0] cmd,
    input  logic [7:0] arg,
    input  logic       has_arg,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [11:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  arg_q, arg_d;
    logic        has_arg_q, has_arg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic        stretch_qtr;
    logic        stall;
    logic        tick;
    logic [1:0]  last_byte;
    logic [7:0]  tx_byte_d;
    logic        tx_bit_d;

    assign busy   = busy_q;
    assign done   = done_q;
    assign nack   = nack_q;
    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;

    always_comb begin
        // A released-SCL quarter waits for the line to actually go high
        stretch_qtr = ((state_q == S_BIT || state_q == S_ACK) && qtr_q == 2'd2)
                    || (state_q == S_STOP && qtr_q == 2'd1);
        stall       = stretch_qtr && !scl_in;
        tick        = busy_q && (div_q == DIV_LAST) && !stall;
        last_byte   = has_arg_q ? 2'd2 : 2'd1;

        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        has_arg_d = has_arg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nack_d    = nack_q;

        if (!busy_q) begin
            div_d = '0;
        end else if (stall) begin
            div_d = div_q;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 12'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d    = addr;
                    cmd_d     = cmd;
                    arg_d     = arg;
                    has_arg_d = has_arg;
                    nack_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = '0;
                    qtr_d     = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        qtr_d   = '0;
                        state_d = S_BIT;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (sda_in) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else if (byte_q == last_byte) begin
                            state_d = S_STOP;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            state_d = S_BIT;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        case (byte_d)
            2'd0:    tx_byte_d = {addr_d, 1'b0};
            2'd1:    tx_byte_d = cmd_d;
            default: tx_byte_d = arg_d;
        endcase
        tx_bit_d = tx_byte_d[3'd7 - bit_d];

        // Pad drives are decoded from the next state so they leave a flop
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_oe_d = (qtr_d == 2'd1);
                sda_oe_d = 1'b1;
            end
            S_BIT: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !tx_bit_d;
            end
            S_ACK: begin
                scl_oe_d = !qtr_d[1];
            end
            S_STOP: begin
                scl_oe_d = (qtr_d == 2'd0);
                sda_oe_d = (qtr_d != 2'd2);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            addr_q    <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            has_arg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            has_arg_q <= has_arg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Bench for i2c_cmd_master: open-drain bus with a byte-decoding
// slave model, table vectors, random frames and corner sequences.
`timescale 1ns/1ps
module tb_i2c_cmd_master;

    localparam int D = 4;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  cmd;
        logic [7:0]  arg;
        logic        has_arg;
        int          nack_at;
        int          stretch;
        int          exp_n;
        logic [23:0] exp_b;
        int          exp_cyc;
        logic        exp_nack;
    } vec_t;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] cmd = '0;
    logic [7:0] arg = '0;
    logic       has_arg = 1'b0;
    logic       busy, done, nack, scl_oe, sda_oe;
    logic       scl_line, sda_line;

    logic       slave_sda = 1'b0;
    int         hold_cnt = 0;
    int         nack_at = -1;
    int         stretch_len = 0;
    int         clr_req = 0;
    int         clr_seen = 0;

    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       scl_c, sda_c;
    int         bitn = 0, fbytes = 0;
    logic [7:0] sh = '0;
    logic [7:0] got[$];
    int         starts = 0, stops = 0, rises = 0, dones = 0;

    int         ncmp = 0;
    int         nbad = 0;

    assign scl_line = ~scl_oe & (hold_cnt == 0);
    assign sda_line = ~sda_oe & ~slave_sda;

    i2c_cmd_master #(.CLK_DIV(D)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .req    (req),
        .addr   (addr),
        .cmd    (cmd),
        .arg    (arg),
        .has_arg(has_arg),
        .busy   (busy),
        .done   (done),
        .nack   (nack),
        .scl_in (scl_line),
        .sda_in (sda_line),
        .scl_oe (scl_oe),
        .sda_oe (sda_oe)
    );

    always #5 sysclk = ~sysclk;

    // Slave address 0x41 acks its address; later bytes ack unless told otherwise
    function automatic logic slave_acks(input int idx, input logic [7:0] b);
        if (idx == 0) return (b == 8'h82);
        return (idx != nack_at);
    endfunction

    always @(negedge sysclk) begin
        scl_c = scl_line;
        sda_c = sda_line;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            got.delete();
            starts = 0; stops = 0; rises = 0; dones = 0;
            bitn = 0; fbytes = 0; slave_sda = 1'b0; hold_cnt = 0;
        end else begin
            if (scl_p && scl_c && sda_p && !sda_c) begin
                starts++;
                bitn = 0;
                fbytes = 0;
            end else if (scl_p && scl_c && !sda_p && sda_c) begin
                stops++;
            end
            if (!scl_p && scl_c) begin
                rises++;
                if (bitn == 8) begin
                    bitn = 0;
                end else begin
                    sh = {sh[6:0], sda_c};
                    bitn++;
                    if (bitn == 8) begin
                        got.push_back(sh);
                        fbytes++;
                    end
                end
            end
            if (scl_p && !scl_c) begin
                if (bitn == 8) begin
                    slave_sda = slave_acks(fbytes - 1, sh);
                    if (fbytes == 2 && stretch_len > 0) hold_cnt = stretch_len + 1;
                end else begin
                    slave_sda = 1'b0;
                end
            end
            if (hold_cnt > 0 && !scl_oe) hold_cnt--;
            if (done) dones++;
        end
        scl_p = scl_c;
        sda_p = sda_c;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: bytes on the wire, NACK outcome and done latency in cycles
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int total = v.has_arg ? 3 : 2;
        logic ok;
        r.exp_b = {v.addr, 1'b0, v.cmd, v.arg};
        r.exp_nack = 1'b0;
        r.exp_n = 0;
        for (int k = 0; k < total; k++) begin
            r.exp_n = k + 1;
            if (k == 0) ok = ({v.addr, 1'b0} == 8'h82);
            else ok = (k != v.nack_at);
            if (!ok) begin
                r.exp_nack = 1'b1;
                break;
            end
        end
        r.exp_cyc = 1 + (2 + 36 * r.exp_n + 3) * D + ((r.exp_n >= 2) ? v.stretch : 0);
        return r;
    endfunction

    task automatic start_req(input vec_t v);
        clr_req++;
        nack_at = v.nack_at;
        stretch_len = v.stretch;
        @(negedge sysclk);
        addr = v.addr;
        cmd = v.cmd;
        arg = v.arg;
        has_arg = v.has_arg;
        req = 1'b1;
        @(posedge sysclk);
        #1;
        req = 1'b0;
        addr = 7'($urandom);
        cmd = 8'($urandom);
        arg = 8'($urandom);
        has_arg = 1'($urandom);
    endtask

    task automatic run_txn(input vec_t v, input string nm, input bit repulse);
        int n = 1;
        bit seen = 0;
        start_req(v);
        chk({nm, ".busy_on"}, 32'(busy), 32'd1);
        while (n < 4000) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (repulse && n == 50) begin
                req = 1'b1;
                addr = 7'h41;
                has_arg = 1'b0;
            end else begin
                req = 1'b0;
            end
            @(posedge sysclk);
            #1;
            n++;
        end
        req = 1'b0;
        chk({nm, ".done_cyc"}, seen ? 32'(n) : 32'hFFFFFFFF, 32'(v.exp_cyc));
        chk({nm, ".busy_off"}, 32'(busy), 32'd0);
        chk({nm, ".nack"}, 32'(nack), 32'(v.exp_nack));
        @(posedge sysclk);
        #1;
        chk({nm, ".done_pulse"}, 32'(done), 32'd0);
        repeat (20) @(posedge sysclk);
        #1;
        chk({nm, ".starts"}, 32'(starts), 32'd1);
        chk({nm, ".stops"}, 32'(stops), 32'd1);
        chk({nm, ".dones"}, 32'(dones), 32'd1);
        chk({nm, ".scl_rises"}, 32'(rises), 32'(9 * v.exp_n + 1));
        chk({nm, ".nbytes"}, 32'(got.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n; i++) begin
            chk($sformatf("%s.byte%0d", nm, i),
                (i < got.size()) ? 32'(got[i]) : 32'hFFFFFFFF,
                32'(v.exp_b[23 - 8 * i -: 8]));
        end
    endtask

    initial begin
        vec_t tab[7];
        vec_t v;
        int r;

        tab[0] = '{7'h41, 8'h10, 8'h80, 1'b1, -1, 0, 3, 24'h821080, 453, 1'b0};
        tab[1] = '{7'h41, 8'h02, 8'h55, 1'b0, -1, 0, 2, 24'h820200, 309, 1'b0};
        tab[2] = '{7'h22, 8'h10, 8'h80, 1'b1, -1, 0, 1, 24'h440000, 165, 1'b1};
        tab[3] = '{7'h41, 8'h01, 8'h33, 1'b1, -1, 37, 3, 24'h820133, 490, 1'b0};
        tab[4] = '{7'h41, 8'h10, 8'h7F, 1'b1, 1, 0, 2, 24'h821000, 309, 1'b1};
        tab[5] = '{7'h41, 8'h01, 8'hC3, 1'b1, 2, 0, 3, 24'h8201C3, 453, 1'b1};
        tab[6] = '{7'h41, 8'hFF, 8'h00, 1'b1, -1, 0, 3, 24'h82FF00, 453, 1'b0};

        repeat (3) @(posedge sysclk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.nack", 32'(nack), 32'd0);
        chk("rst.scl_oe", 32'(scl_oe), 32'd0);
        chk("rst.sda_oe", 32'(sda_oe), 32'd0);
        @(negedge sysclk);
        rst = 1'b0;
        repeat (2) @(posedge sysclk);

        for (int i = 0; i < 7; i++) begin
            run_txn(tab[i], $sformatf("tab%0d", i), 1'b0);
        end

        run_txn(tab[0], "repulse", 1'b1);

        start_req(tab[0]);
        repeat (40) @(posedge sysclk);
        #1;
        for (int i = 0; i < 20 && !scl_oe; i++) begin
            @(posedge sysclk);
            #1;
        end
        chk("midrst.busy_pre", 32'(busy), 32'd1);
        chk("midrst.scl_pre", 32'(scl_oe), 32'd1);
        @(negedge sysclk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.scl_oe", 32'(scl_oe), 32'd0);
        chk("midrst.sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        repeat (4) @(posedge sysclk);
        run_txn(tab[0], "post_rst", 1'b0);

        for (int i = 0; i < 12; i++) begin
            v.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h41;
            v.cmd = 8'($urandom);
            v.arg = 8'($urandom);
            v.has_arg = 1'($urandom);
            r = $urandom_range(0, 5);
            v.nack_at = (r == 4) ? 1 : (r == 5) ? 2 : -1;
            v.stretch = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_master.md
# i2c_cmd_master

Open-drain I2C write-only master that sends command frames to the motor-control I2C slave (7-bit address 0x41): START, address+W, command byte, optional argument byte, STOP. It turns a single-cycle request from fabric logic into a complete bus transaction. It reports completion and NACK, and honours slave clock stretching. It runs on the 48 MHz `sysclk` and drives SCL/SDA through open-drain IO cells.

## Interface
Parameters:
- `CLK_DIV`, 120, sysclk cycles per SCL quarter-period (120 gives 100 kHz at 48 MHz); legal range 2..4095.

Ports:
- `sysclk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in 1: start a transaction; sampled only when `busy`=0.
- `addr` in 7: slave address; latched on accepted `req`.
- `cmd` in 8: command byte (0x10 set PWM, 0x01/0x02 motor); latched on accepted `req`.
- `arg` in 8: argument byte; latched on accepted `req`.
- `has_arg` in 1: 1 = send `arg` after `cmd`; latched on accepted `req`.
- `busy` out 1: high from the cycle after acceptance until the cycle `done` pulses.
- `done` out 1: one-cycle pulse at the end of the transaction.
- `nack` out 1: valid with `done`; 1 if any byte was NACKed; holds until the next accepted `req`.
- `scl_in` in 1: SCL pad input.
- `sda_in` in 1: SDA pad input.
- `scl_oe` out 1: 1 pulls SCL low, 0 releases it.
- `sda_oe` out 1: 1 pulls SDA low, 0 releases it.

## Operation
- Reset values: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `nack`=0. The divider counter, quarter counter, bit counter and byte counter are all 0. State is IDLE.
- Divider: counts 0..CLK_DIV-1 while `busy`. A quarter tick fires at CLK_DIV-1. The divider is cleared on acceptance.
- Byte list: B0={addr,1'b0}, B1=cmd, B2=arg (sent only if `has_arg`). N is 2 or 3.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: both lines released. On `req`=1, latch inputs, clear `nack`, set `busy`, and go to START.
- START (2 quarters):
  - q0: SCL released, SDA pulled.
  - q1: SCL pulled, SDA pulled.
  - Then go to BIT.
- BIT (4 quarters per bit, bits sent MSB first):
  - q0: SCL pulled; `sda_oe` = ~bit.
  - q1: SCL pulled.
  - q2: SCL released. The quarter tick is ignored while `scl_in`=0; the divider holds at 0 during this clock stretch.
  - q3: SCL released.
  - After bit 0, go to ACK.
- ACK (4 quarters): same SCL pattern as BIT, with `sda_oe`=0.
  - `sda_in` is sampled on the q3 tick. 1 means NACK: set `nack` and go to STOP.
  - Otherwise, if bytes remain, go to BIT with the next byte; else go to STOP.
- STOP (3 quarters):
  - q0: SCL pulled, SDA pulled.
  - q1: SCL released, SDA pulled; the stretch rule applies.
  - q2: SCL released, SDA released.
  - Then go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `req` while `busy` is ignored and not queued.
- `rst` mid-transaction releases both lines immediately; the bus may be left mid-frame, and a slave timeout or the next START recovers it.
- The block does not detect arbitration loss or bus-busy; it is the single master on the bus.

## Timing
- Acceptance edge E: `busy`=1 from E+1. The first quarter (START q0) occupies E+1..E+CLK_DIV.
- Total quarters Q = 2 + 36·N + 3 (no NACK): 77 for N=2, 113 for N=3.
- Without stretching, `done` is high exactly in cycle E+1+Q·CLK_DIV, and `busy` falls in the same cycle.
- NACK on byte k (0-based): Q = 2 + 36·(k+1) + 3.
- Stretching adds exactly the number of cycles `scl_in` stays low during SCL-released quarters.
- SDA changes only in q0 while SCL is pulled, at least CLK_DIV cycles before SCL release. START/STOP edges change SDA only while SCL is released.
- Output regs feed the pads directly; outputs are not combinational from any input.

## Test plan
- CLK_DIV=4, addr=0x41, cmd=0x10, arg=0x80, has_arg=1, slave model ACKs all bytes → SDA bytes decoded at SCL rising edges are 0x82, 0x10, 0x80; START before and STOP after; `done` at E+1+452; `nack`=0.
- has_arg=0, cmd=0x02 → bytes 0x82, 0x02 only; `done` at E+1+308.
- Slave NACKs the address (addr=0x22) → byte 0x44 is sent, then STOP; `done` at E+1+164 with `nack`=1; no further SCL pulses.
- Slave holds SCL low for 37 cycles during the ACK of byte 1 → `done` delayed by exactly 37 cycles; data is unchanged.
- `req` pulsed again while `busy` → no effect on the bus; exactly one `done`.
- `rst` asserted mid-byte → `scl_oe`=`sda_oe`=`busy`=0 in the same cycle. A following `req` produces a clean, full frame.
